// File: rtl/vga_timing_gen_multi.sv
// Multi-mode VGA timing generator. The mode is latched only at the frame wrap.
// The block has a built-in pixel-strobe divider and delayed hs/vs/de outputs.
module vga_timing_gen_multi #(
  parameter int CLK_DIV      = 4,
  parameter int DEFAULT_MODE = 0,
  parameter int PIPE_DLY     = 0,
  parameter int HW           = 11,
  parameter int VW           = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [1:0]    mode_i,
  output logic [1:0]    mode_o,
  output logic          pix_stb_o,
  output logic [HW-1:0] hcount_o,
  output logic [VW-1:0] vcount_o,
  output logic          de_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = PIPE_DLY + 1;

  function automatic logic mode_pol(input logic [1:0] m);
    return (m == 2'd1) || (m == 2'd3);
  endfunction

  localparam logic [1:0] DEF_MODE = DEFAULT_MODE[1:0];
  localparam logic       DEF_POL  = mode_pol(DEF_MODE);

  logic [DW-1:0] div_cnt;
  logic [1:0]    mode_q;
  logic          stb, h_last, v_last;
  logic [HW-1:0] hd, hf, hr, ht, hs_beg, hs_end;
  logic [VW-1:0] vd, vf, vr, vt, vs_beg, vs_end;
  logic          pol, de_d, hs_d, vs_d;
  logic [PW-1:0] de_p, hs_p, vs_p;

  always_comb begin
    hd = HW'(1366); hf = HW'(70); hr = HW'(143); ht = HW'(1792);
    vd = VW'(768);  vf = VW'(3);  vr = VW'(3);   vt = VW'(798);
    unique case (mode_q)
      2'd0: begin
        hd = HW'(640);  hf = HW'(16); hr = HW'(96);  ht = HW'(800);
        vd = VW'(480);  vf = VW'(10); vr = VW'(2);   vt = VW'(525);
      end
      2'd1: begin
        hd = HW'(800);  hf = HW'(40); hr = HW'(128); ht = HW'(1056);
        vd = VW'(600);  vf = VW'(1);  vr = VW'(4);   vt = VW'(628);
      end
      2'd2: begin
        hd = HW'(1024); hf = HW'(24); hr = HW'(136); ht = HW'(1344);
        vd = VW'(768);  vf = VW'(3);  vr = VW'(6);   vt = VW'(806);
      end
      default: ;
    endcase
  end

  assign pol    = mode_pol(mode_q);
  assign hs_beg = hd + hf;
  assign hs_end = hs_beg + hr;
  assign vs_beg = vd + vf;
  assign vs_end = vs_beg + vr;

  assign stb    = en_i && (div_cnt == DW'(CLK_DIV - 1));
  assign h_last = (hcount_o == ht - HW'(1));
  assign v_last = (vcount_o == vt - VW'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_cnt   <= '0;
      pix_stb_o <= 1'b0;
    end else begin
      pix_stb_o <= stb;
      if (en_i) div_cnt <= stb ? '0 : div_cnt + DW'(1);
    end
  end

  // A requested mode takes effect only at the last pixel of a frame, so that
  // the new mode's totals start cleanly at (0,0).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hcount_o <= '0;
      vcount_o <= '0;
      mode_q   <= DEF_MODE;
    end else if (stb) begin
      if (h_last) begin
        hcount_o <= '0;
        if (v_last) begin
          vcount_o <= '0;
          mode_q   <= mode_i;
        end else begin
          vcount_o <= vcount_o + VW'(1);
        end
      end else begin
        hcount_o <= hcount_o + HW'(1);
      end
    end
  end

  assign de_d = (hcount_o < hd) && (vcount_o < vd);
  assign hs_d = ((hcount_o >= hs_beg) && (hcount_o < hs_end)) ? pol : ~pol;
  assign vs_d = ((vcount_o >= vs_beg) && (vcount_o < vs_end)) ? pol : ~pol;

  // Stage 0 is the registered decode. The remaining stages add the
  // downstream alignment delay.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      de_p          <= '0;
      hs_p          <= {PW{~DEF_POL}};
      vs_p          <= {PW{~DEF_POL}};
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      de_p          <= PW'({de_p, de_d});
      hs_p          <= PW'({hs_p, hs_d});
      vs_p          <= PW'({vs_p, vs_d});
      line_start_o  <= pix_stb_o && (hcount_o == '0);
      frame_start_o <= pix_stb_o && (hcount_o == '0) && (vcount_o == '0);
    end
  end

  assign de_o   = de_p[PIPE_DLY];
  assign hs_o   = hs_p[PIPE_DLY];
  assign vs_o   = vs_p[PIPE_DLY];
  assign mode_o = mode_q;

endmodule

// File: tb/tb_vga_timing_gen_multi.sv
// Randomized bench for vga_timing_gen_multi. Four instances with different
// divider, mode and delay settings are checked against a frame-position model.
module tb_vga_timing_gen_multi;

  localparam int NI = 4;

  localparam int HD [4] = '{640, 800, 1024, 1366};
  localparam int HF [4] = '{16, 40, 24, 70};
  localparam int HR [4] = '{96, 128, 136, 143};
  localparam int HT [4] = '{800, 1056, 1344, 1792};
  localparam int VD [4] = '{480, 600, 768, 768};
  localparam int VF [4] = '{10, 1, 3, 3};
  localparam int VR [4] = '{2, 4, 6, 3};
  localparam int VT [4] = '{525, 628, 806, 798};
  localparam bit POL [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  function automatic int div_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 2 : 16;
  endfunction

  function automatic int dmode_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 3 : 2;
  endfunction

  function automatic int pipe_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : (k == 2) ? 7 : 1;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [1:0] mode_req;

  logic [NI-1:0][1:0]  mode_w;
  logic [NI-1:0][10:0] h_w;
  logic [NI-1:0][9:0]  v_w;
  logic [NI-1:0]       stb_w, de_w, hs_w, vs_w, ls_w, fs_w;

  int tests_run;
  int tests_failed;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_timing_gen_multi #(
      .CLK_DIV(div_of(g)),
      .DEFAULT_MODE(dmode_of(g)),
      .PIPE_DLY(pipe_of(g)),
      .HW(11),
      .VW(10)
    ) u_dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .en_i(en),
      .mode_i(mode_req),
      .mode_o(mode_w[g]),
      .pix_stb_o(stb_w[g]),
      .hcount_o(h_w[g]),
      .vcount_o(v_w[g]),
      .de_o(de_w[g]),
      .hs_o(hs_w[g]),
      .vs_o(vs_w[g]),
      .line_start_o(ls_w[g]),
      .frame_start_o(fs_w[g])
    );
  end

  // Reference state per instance. It holds the count of enabled cycles since
  // reset and the strobe-count position inside the current frame. The history
  // holds the expected {de,hs,vs} decode produced at each of the last 8 edges.
  int       m_en   [NI];
  int       m_pos  [NI];
  int       m_mode [NI];
  bit       m_stb  [NI];
  bit       m_ls   [NI];
  bit       m_fs   [NI];
  bit [2:0] m_hist [NI][8];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input int k);
    int md, ht, h, v, frame;
    bit pol, hs_a, vs_a;
    bit [2:0] dec;
    md = m_mode[k];
    ht = HT[md];
    h  = m_pos[k] % ht;
    v  = m_pos[k] / ht;
    if (!rst_n) begin
      pol = POL[dmode_of(k)];
      for (int i = 0; i < 8; i++) m_hist[k][i] = {1'b0, ~pol, ~pol};
      m_en[k]   = 0;
      m_pos[k]  = 0;
      m_mode[k] = dmode_of(k);
      m_stb[k]  = 1'b0;
      m_ls[k]   = 1'b0;
      m_fs[k]   = 1'b0;
    end else begin
      pol  = POL[md];
      hs_a = (h >= HD[md] + HF[md]) && (h < HD[md] + HF[md] + HR[md]);
      vs_a = (v >= VD[md] + VF[md]) && (v < VD[md] + VF[md] + VR[md]);
      dec  = {(h < HD[md]) && (v < VD[md]), hs_a ? pol : ~pol, vs_a ? pol : ~pol};
      for (int i = 7; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
      m_hist[k][0] = dec;
      m_ls[k]  = m_stb[k] && (h == 0);
      m_fs[k]  = m_ls[k] && (v == 0);
      m_stb[k] = 1'b0;
      if (en) begin
        m_en[k]++;
        if (m_en[k] % div_of(k) == 0) begin
          m_stb[k] = 1'b1;
          m_pos[k]++;
          frame = HT[md] * VT[md];
          if (m_pos[k] == frame) begin
            m_pos[k]  = 0;
            m_mode[k] = int'(mode_req);
          end
        end
      end
    end
  endtask

  task automatic check_all(input int k);
    int ht;
    bit [2:0] d;
    string u;
    ht = HT[m_mode[k]];
    d  = m_hist[k][pipe_of(k)];
    u  = $sformatf("u%0d.", k);
    checkOutput({u, "mode"},        32'(mode_w[k]), 32'(m_mode[k]));
    checkOutput({u, "pix_stb"},     32'(stb_w[k]),  32'(m_stb[k]));
    checkOutput({u, "hcount"},      32'(h_w[k]),    32'(m_pos[k] % ht));
    checkOutput({u, "vcount"},      32'(v_w[k]),    32'(m_pos[k] / ht));
    checkOutput({u, "de"},          32'(de_w[k]),   32'(d[2]));
    checkOutput({u, "hs"},          32'(hs_w[k]),   32'(d[1]));
    checkOutput({u, "vs"},          32'(vs_w[k]),   32'(d[0]));
    checkOutput({u, "line_start"},  32'(ls_w[k]),   32'(m_ls[k]));
    checkOutput({u, "frame_start"}, 32'(fs_w[k]),   32'(m_fs[k]));
  endtask

  task automatic applyStimulus(input bit r, input bit e, input logic [1:0] m);
    rst_n    = r;
    en       = e;
    mode_req = m;
    @(posedge clk);
    for (int k = 0; k < NI; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < NI; k++) check_all(k);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)));

    for (int i = 0; i < 20000; i++) applyStimulus(1'b1, 1'b1, 2'($urandom_range(0, 3)));

    // Freeze unit 0 right after it steps onto h=300, then resume.
    for (int i = 0; i < 4000 && !(m_stb[0] && (m_pos[0] % HT[m_mode[0]] == 300)); i++)
      applyStimulus(1'b1, 1'b1, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 2'($urandom_range(0, 3)));

    for (int i = 0; i < 25000; i++)
      applyStimulus(($urandom_range(0, 4999) != 0), ($urandom_range(0, 4) != 0),
                    2'($urandom_range(0, 3)));

    applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 12000; i++) applyStimulus(1'b1, 1'b1, 2'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen_multi.md
Name: vga_timing_gen_multi

Overview:
- Multi-mode VGA timing generator. Successor to the fixed-mode VGA block.
- Mode (640x480 / 800x600 / 1024x768 / 1366x768) is selectable at runtime. A change applies only at a frame boundary, so no broken frame is ever emitted.
- Contains its own pixel-strobe divider and per-mode sync polarity.
- Emits line-start and frame-start pulses, plus a configurable sync/DE delay to align with downstream character-generator latency.
- Sits between the system clock domain and the chargen/pixel pipeline.

Parameters:
- CLK_DIV, 4, clock cycles per pixel strobe (1..16). 1 = strobe every enabled cycle.
- DEFAULT_MODE, 0, mode loaded at reset (0..3).
- PIPE_DLY, 0, extra clk cycles of delay on hs/vs/de (0..7).
- HW, 11, horizontal counter width.
- VW, 10, vertical counter width.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  synchronous active-low reset.
- en_i  in  1  global enable; when low, the divider and counters freeze.
- mode_i  in  2  requested mode: 0 640x480, 1 800x600, 2 1024x768, 3 1366x768.
- mode_o  out  2  currently active mode.
- pix_stb_o  out  1  one-clk pixel strobe.
- hcount_o  out  HW  horizontal position.
- vcount_o  out  VW  vertical position.
- de_o  out  1  display-area enable.
- hs_o  out  1  horizontal sync.
- vs_o  out  1  vertical sync.
- line_start_o  out  1  one-clk pulse when h wraps to 0.
- frame_start_o  out  1  one-clk pulse when (h,v) wraps to (0,0).

Behaviour:
- Mode table, given as display/front/sync/back, with hs/vs polarity (1 = active-high):
  - mode 0: h 640/16/96/48 (total 800); v 480/10/2/33 (total 525); pol 0/0.
  - mode 1: h 800/40/128/88 (total 1056); v 600/1/4/23 (total 628); pol 1/1.
  - mode 2: h 1024/24/136/160 (total 1344); v 768/3/6/29 (total 806); pol 0/0.
  - mode 3: h 1366/70/143/213 (total 1792); v 768/3/3/24 (total 798); pol 1/1.
- Reset (rst_ni low at a clk edge):
  - divider, hcount, vcount = 0; active mode = DEFAULT_MODE.
  - pix_stb_o, de_o, line_start_o, frame_start_o = 0.
  - hs_o, vs_o = inactive level of DEFAULT_MODE; delay pipeline flushed to the same values.
  - Reset mid-frame takes effect on the next edge; no partial-state retention.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 only while en_i = 1.
  - pix_stb_o is registered; high for one clk on the cycle after div_cnt = CLK_DIV-1 with en_i = 1.
  - With en_i low, div_cnt holds and pix_stb_o = 0.
- Counters: advance in the same clk edge that the strobe condition is met (counters and pix_stb_o update together).
  - hcount increments; at htotal-1 it wraps to 0 and vcount increments.
  - At vtotal-1 (with an h wrap), vcount wraps to 0.
- Mode switch:
  - mode_i is sampled only on the (htotal-1, vtotal-1) → (0,0) wrap edge. The new mode's totals apply from (0,0).
  - Changes to mode_i at any other time have no effect.
  - mode_o = active mode register.
- Decode: combinational from the counters, then registered, so outputs land 1 clk after the counter update.
  - de = h < hd && v < vd.
  - hs active when hd+hf ≤ h < hd+hf+hr; vs active when vd+vf ≤ v < vd+vf+vr.
  - Output level = pol when active, ~pol otherwise.
  - line_start / frame_start: high for exactly 1 clk, asserted 1 clk after the wrap edge.
- Delay: hs_o, vs_o and de_o pass through a further PIPE_DLY-stage clk shift register, for a total lag of 1+PIPE_DLY clk behind hcount_o/vcount_o. Pulses and counters are not delayed.
- Widths: comparisons are unsigned at HW/VW; all table sums fit without overflow.

Test Plan:
- Reset: CLK_DIV=4, hold rst_ni low 3 clk → hcount=vcount=0, de_o=0, hs_o=vs_o=1 (mode 0 inactive), mode_o=0, no pix_stb_o. After release, first pix_stb_o on clk 4 and a strobe every 4 clk.
- Mode 0 line/frame, CLK_DIV=1:
  - hs_o low for exactly 96 strobes, starting 1 clk after hcount=656.
  - de_o high for 640 strobes per line during lines 0..479.
  - line_start_o every 800 clk; frame_start_o every 420000 clk.
  - vs_o low on lines 490..491.
- Mode switch mid-frame: set mode_i=1 at v=100 → mode_o stays 0 until the (799,524) wrap, then becomes 1. Next line total is 1056 and hs/vs are active-high (hs_o=0 at reset of frame).
- en_i freeze: drop en_i for 10 clk at h=300 → hcount holds 300, no pix_stb_o. After re-assert, counting resumes at 301 with no skipped count.
- PIPE_DLY=2: de_o rises 3 clk after hcount becomes 0 on line 0; line_start_o still asserts 1 clk after the wrap.
- Reset mid-frame: assert rst_ni low at h=500, v=200 in mode 2 → next clk counters are 0 and mode_o=DEFAULT_MODE (0). frame_start_o is not asserted on reset.
